// File: rtl/mostra_seq_pkg.sv
// Shared constants for the sequence playback datapath (mostra_sequencia).
// State codes, 1 kHz default timings and debug code width.
package mostra_seq_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] SHOW  = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam int T_ON_PADRAO  = 500;
   localparam int T_OFF_PADRAO = 250;
   localparam int DB_W         = 4;

   function automatic int maximo(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mostra_seq_if.sv
// Bundle between mostra_sequencia, the game FSM side and the sync game ROM.
// slave = playback block, master = FSM/ROM side.
interface mostra_seq_if
   import mostra_seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) ();

   logic              iniciar;
   logic [ADDR_W-1:0] limite;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              pronto;
   logic [DB_W-1:0]   db_estado;

   modport master (
      output iniciar, limite, rom_data,
      input  rom_addr, leds, ocupado, pronto, db_estado
   );

   modport slave (
      input  iniciar, limite, rom_data,
      output rom_addr, leds, ocupado, pronto, db_estado
   );

endinterface

// File: rtl/mostra_sequencia_temporizador.sv
// temporizador_mostra: clear/count-up timer with terminal-count compare.
// One instance times both the lit window and the dark gap.
module temporizador_mostra #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic         conta,
   input  logic [W-1:0] alvo,
   output logic [W-1:0] valor,
   output logic         fim
);

   always_ff @(posedge clock) begin
      if (reset || carrega)
         valor <= '0;
      else if (conta)
         valor <= valor + W'(1);
   end

   assign fim = (valor == alvo);

endmodule

// File: rtl/mostra_sequencia.sv
// Sequence playback: sync ROM -> LEDs, lit window then dark gap per element.
// Optional MOSTRA_SEQUENCIA_ABORTA_EN adds the abortar input.
module mostra_sequencia
   import mostra_seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int T_ON   = T_ON_PADRAO,
   parameter int T_OFF  = T_OFF_PADRAO
) (
   input  logic clock,
   input  logic reset,
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
   input  logic abortar,
`endif
   mostra_seq_if.slave bus
);

   localparam int TW = $clog2(maximo(T_ON, T_OFF) + 1);
   localparam logic [TW-1:0] ON_FIM  = TW'(T_ON - 1);
   localparam logic [TW-1:0] OFF_FIM = TW'(T_OFF - 1);
   localparam logic [TW-1:0] PRE_CNT = TW'((T_OFF > 1) ? T_OFF - 2 : 0);

   logic [2:0]        st;
   logic [ADDR_W-1:0] lim_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] leds_q;
   logic              ultimo;
   logic [TW-1:0]     t_val;
   logic [TW-1:0]     alvo;
   logic              t_fim;
   logic              t_carrega;
   logic              t_conta;
   logic              pre;
   logic              aborta;

`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
   assign aborta = abortar && (st != IDLE);
`else
   assign aborta = 1'b0;
`endif

   // The ROM is registered, so the next address goes out one cycle
   // before FETCH; that way FETCH sees the new word after one cycle.
   always_comb begin
      alvo      = (st == SHOW) ? ON_FIM : OFF_FIM;
      t_conta   = (st == SHOW) || (st == GAP);
      t_carrega = (st == IDLE) || (st == FETCH) ||
                  ((st == SHOW) && t_fim) || aborta;
      pre       = 1'b0;
      if (T_OFF == 1)
         pre = (st == SHOW) && t_fim;
      else
         pre = (st == GAP) && (t_val == PRE_CNT);
   end

   temporizador_mostra #(.W(TW)) u_tempo (
      .clock   (clock),
      .reset   (reset),
      .carrega (t_carrega),
      .conta   (t_conta),
      .alvo    (alvo),
      .valor   (t_val),
      .fim     (t_fim)
   );

   always_ff @(posedge clock) begin
      if (reset || aborta || (st == IDLE) || (st == DONE)) begin
         addr_q <= '0;
         ultimo <= 1'b0;
      end else if (pre) begin
         if (addr_q == lim_q)
            ultimo <= 1'b1;
         else
            addr_q <= addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st     <= IDLE;
         lim_q  <= '0;
         leds_q <= '0;
      end else if (aborta) begin
         st     <= IDLE;
         leds_q <= '0;
      end else begin
         unique case (st)
            IDLE: begin
               leds_q <= '0;
               if (bus.iniciar) begin
                  lim_q <= bus.limite;
                  st    <= FETCH;
               end
            end
            FETCH: begin
               leds_q <= bus.rom_data;
               st     <= SHOW;
            end
            SHOW: begin
               if (t_fim) begin
                  leds_q <= '0;
                  st     <= GAP;
               end
            end
            GAP: begin
               if (t_fim)
                  st <= ultimo ? DONE : FETCH;
            end
            DONE: st <= IDLE;
            default: begin
               leds_q <= '0;
               st     <= IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr  = addr_q;
   assign bus.leds      = leds_q;
   assign bus.ocupado   = (st != IDLE);
   assign bus.pronto    = (st == DONE);
   assign bus.db_estado = DB_W'(st);

endmodule

// File: tb/tb_mostra_sequencia.sv
// Bench for mostra_sequencia: cycle-level reference trace built from the
// element timeline (fetch, lit window, dark gap, done pulse).
module tb_mostra_sequencia;

   localparam int T_ON  = 4;
   localparam int T_OFF = 2;
   localparam int P     = 1 + T_ON + T_OFF;

   logic clk;
   logic rst;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
   logic abortar;
`endif
   logic [3:0] rom [16];
   int checks;
   int errors;

   mostra_seq_if #(.ADDR_W(4), .DATA_W(4)) bus ();

   mostra_sequencia #(
      .ADDR_W (4),
      .DATA_W (4),
      .T_ON   (T_ON),
      .T_OFF  (T_OFF)
   ) dut (
      .clock   (clk),
      .reset   (rst),
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
      .abortar (abortar),
`endif
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sync ROM, one cycle of latency
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic esperado(input int j, input int lim,
                           output logic [3:0] el, output logic eo,
                           output logic ep, output logic [3:0] ee);
      int tot;
      int e;
      int p;
      tot = (lim + 1) * P + 1;
      el = 4'd0;
      eo = 1'b1;
      ep = 1'b0;
      ee = 4'd0;
      if (j > tot) begin
         eo = 1'b0;
      end else if (j == tot) begin
         ep = 1'b1;
         ee = 4'd4;
      end else begin
         e = (j - 1) / P;
         p = (j - 1) % P;
         if (p == 0) begin
            ee = 4'd1;
         end else if (p <= T_ON) begin
            ee = 4'd2;
            el = rom[e];
         end else begin
            ee = 4'd3;
         end
      end
   endtask

   task automatic run_seq(input int lim, input bit ruido);
      int tot;
      int maxa;
      int np;
      logic [3:0] el;
      logic [3:0] ee;
      logic eo;
      logic ep;
      tot  = (lim + 1) * P + 1;
      maxa = 0;
      np   = 0;
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.limite  = 4'(lim);
      @(posedge clk);
      for (int j = 1; j <= tot + 3; j++) begin
         @(negedge clk);
         esperado(j, lim, el, eo, ep, ee);
         checks++;
         if (bus.leds !== el) begin
            errors++;
            $display("FAIL leds L=%0d cyc=%0d got=%0d exp=%0d",
                     lim, j, bus.leds, el);
         end
         checks++;
         if (bus.ocupado !== eo) begin
            errors++;
            $display("FAIL ocupado L=%0d cyc=%0d got=%0b exp=%0b",
                     lim, j, bus.ocupado, eo);
         end
         checks++;
         if (bus.pronto !== ep) begin
            errors++;
            $display("FAIL pronto L=%0d cyc=%0d got=%0b exp=%0b",
                     lim, j, bus.pronto, ep);
         end
         checks++;
         if (bus.db_estado !== ee) begin
            errors++;
            $display("FAIL db_estado L=%0d cyc=%0d got=%0d exp=%0d",
                     lim, j, bus.db_estado, ee);
         end
         checks++;
         if (int'(bus.rom_addr) > lim || (!eo && bus.rom_addr !== 4'd0)) begin
            errors++;
            $display("FAIL rom_addr L=%0d cyc=%0d got=%0d max=%0d",
                     lim, j, bus.rom_addr, lim);
         end
         if (int'(bus.rom_addr) > maxa) maxa = int'(bus.rom_addr);
         if (bus.pronto === 1'b1) np++;
         if (ruido && j < tot - 1) begin
            bus.iniciar = 1'($urandom_range(0, 1));
            bus.limite  = 4'($urandom);
         end else begin
            bus.iniciar = 1'b0;
         end
      end
      checks++;
      if (np != 1) begin
         errors++;
         $display("FAIL pronto_count L=%0d got=%0d exp=1", lim, np);
      end
      checks++;
      if (maxa != lim) begin
         errors++;
         $display("FAIL rom_addr_max L=%0d got=%0d exp=%0d", lim, maxa, lim);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus.leds !== 4'd0 || bus.ocupado !== 1'b0 ||
             bus.pronto !== 1'b0 || bus.db_estado !== 4'd0 ||
             bus.rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d leds=%0d ocup=%0b pronto=%0b est=%0d addr=%0d exp=all0",
                     i, bus.leds, bus.ocupado, bus.pronto,
                     bus.db_estado, bus.rom_addr);
         end
      end
   endtask

   task automatic test_sequencia();
      run_seq(2, 1'b0);
   endtask

   task automatic test_limites();
      run_seq(0, 1'b0);
      run_seq(15, 1'b0);
   endtask

   task automatic test_ruido();
      run_seq(3, 1'b1);
      run_seq(6, 1'b1);
   endtask

   task automatic test_aleatorio();
      for (int r = 0; r < 4; r++)
         run_seq(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_reset_meio();
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.limite  = 4'd3;
      @(posedge clk);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
      end
      checks++;
      if (bus.leds !== rom[1] || bus.ocupado !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_show leds=%0d exp=%0d ocup=%0b",
                  bus.leds, rom[1], bus.ocupado);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.leds !== 4'd0 || bus.rom_addr !== 4'd0 ||
          bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0 ||
          bus.pronto !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid leds=%0d addr=%0d ocup=%0b est=%0d exp=all0",
                  bus.leds, bus.rom_addr, bus.ocupado, bus.db_estado);
      end
      rst = 1'b0;
      run_seq(2, 1'b0);
   endtask

`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
   task automatic test_abortar();
      int np;
      np = 0;
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.limite  = 4'd3;
      @(posedge clk);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
      end
      checks++;
      if (bus.db_estado !== 4'd3) begin
         errors++;
         $display("FAIL pre_abort_gap est=%0d exp=3", bus.db_estado);
      end
      abortar = 1'b1;
      @(negedge clk);
      abortar = 1'b0;
      checks++;
      if (bus.leds !== 4'd0 || bus.rom_addr !== 4'd0 ||
          bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
         errors++;
         $display("FAIL abort leds=%0d addr=%0d ocup=%0b pronto=%0b exp=all0",
                  bus.leds, bus.rom_addr, bus.ocupado, bus.pronto);
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.pronto === 1'b1) np++;
      end
      checks++;
      if (np != 0) begin
         errors++;
         $display("FAIL abort_pronto got=%0d exp=0", np);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) begin
         logic [3:0] um;
         um = 4'd1;
         rom[i] = um << (i % 4);
      end
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.iniciar = 1'b0;
      bus.limite  = 4'd0;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
      abortar = 1'b0;
`endif
      repeat (3) @(posedge clk);
      test_reset();
      test_sequencia();
      test_limites();
      test_ruido();
      test_aleatorio();
      test_reset_meio();
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
      test_abortar();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
